// File: rtl/fft_bitrev_reorder_if.sv
// Purpose: sample stream bundle around the bit-reversal reorder buffer (SDF side in, natural-order side out).
// Latency: none, wires only.
// Backpressure: none; the input is valid-only and the output is a gap-free burst the consumer must take.
interface fft_bitrev_reorder_if #(
  parameter int FLOAT_PRECISION = 64,
  parameter int logn            = 8
) ();
  logic                       in_valid;
  logic [FLOAT_PRECISION-1:0] di_re;
  logic [FLOAT_PRECISION-1:0] di_im;
  logic                       out_valid;
  logic [FLOAT_PRECISION-1:0] do_re;
  logic [FLOAT_PRECISION-1:0] do_im;
  logic [logn-1:0]            out_idx;
  logic                       out_last;
  logic                       busy;

  // Upstream/downstream environment: feeds samples, observes the ordered stream.
  modport master (
    output in_valid, di_re, di_im,
    input  out_valid, do_re, do_im, out_idx, out_last, busy
  );

  // Reorder block: takes bit-reversed samples, emits natural-order samples.
  modport slave (
    input  in_valid, di_re, di_im,
    output out_valid, do_re, do_im, out_idx, out_last, busy
  );
endinterface

// File: rtl/fft_bitrev_reorder.sv
// Purpose: ping-pong reorder of bit-reversed SDF FFT frames into natural bin order.
// Latency: last input sample accepted at edge E -> bin 0 at edge E+1, bin N-1 at edge E+N.
// Backpressure: none; input gaps are absorbed, each frame is replayed as one gap-free burst.
module fft_bitrev_reorder #(
  parameter int FLOAT_PRECISION = 64,
  parameter int logn            = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  fft_bitrev_reorder_if.slave   bus
);

  localparam int                W        = 2 * FLOAT_PRECISION;
  localparam int                N        = 1 << logn;
  localparam logic [logn-1:0]   CNT_LAST = {logn{1'b1}};

  typedef enum logic {
    R_IDLE = 1'b0,
    R_OUT  = 1'b1
  } rstate_t;

  function automatic logic [logn-1:0] bitrev(input logic [logn-1:0] v);
    logic [logn-1:0] r;
    for (int b = 0; b < logn; b++) begin
      r[b] = v[logn-1-b];
    end
    return r;
  endfunction

  // Both banks live in one array; the top address bit selects the bank.
  logic [W-1:0]      mem_q [2*N];

  logic [logn-1:0]   wcnt_q, wcnt_d;
  logic              wbank_q, wbank_d;
  logic              frame_rdy;
  logic [logn:0]     wr_addr;

  rstate_t           state_q, state_d;
  logic [logn-1:0]   rcnt_q, rcnt_d;
  logic              rbank_q, rbank_d;
  logic              rd_en;
  logic [logn:0]     rd_addr;
  logic [W-1:0]      rd_dat;

  logic                       out_valid_q;
  logic                       out_last_q;
  logic [logn-1:0]            out_idx_q;
  logic [FLOAT_PRECISION-1:0] do_re_q;
  logic [FLOAT_PRECISION-1:0] do_im_q;

  // Write side: count accepted samples, flip banks and raise frame-ready on the N-th one.
  always_comb begin
    wcnt_d    = wcnt_q;
    wbank_d   = wbank_q;
    frame_rdy = 1'b0;
    if (bus.in_valid) begin
      wcnt_d = wcnt_q + 1'b1;
      if (wcnt_q == CNT_LAST) begin
        wbank_d   = ~wbank_q;
        frame_rdy = 1'b1;
      end
    end
  end

  assign wr_addr = {wbank_q, bitrev(wcnt_q)};

  // Write-side counters; a reset drops any partial frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt_q  <= '0;
      wbank_q <= 1'b0;
    end else begin
      wcnt_q  <= wcnt_d;
      wbank_q <= wbank_d;
    end
  end

  // Sample storage, scattered to its bit-reversed slot; contents are never reset.
  always_ff @(posedge clk) begin
    if (bus.in_valid) begin
      mem_q[wr_addr] <= {bus.di_re, bus.di_im};
    end
  end

  // Read FSM next state: replay N bins, chaining straight into a frame that completes on the last bin.
  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    rbank_d = rbank_q;
    rd_en   = 1'b0;
    case (state_q)
      R_IDLE: begin
        if (frame_rdy) begin
          state_d = R_OUT;
          rcnt_d  = '0;
          rbank_d = wbank_q;
        end
      end
      R_OUT: begin
        rd_en  = 1'b1;
        rcnt_d = rcnt_q + 1'b1;
        if (rcnt_q == CNT_LAST) begin
          rcnt_d = '0;
          if (frame_rdy) begin
            rbank_d = wbank_q;
          end else begin
            state_d = R_IDLE;
          end
        end
      end
      default: begin
        state_d = R_IDLE;
      end
    endcase
  end

  // Read FSM state register; a reset abandons any replay in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= R_IDLE;
      rcnt_q  <= '0;
      rbank_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rcnt_q  <= rcnt_d;
      rbank_q <= rbank_d;
    end
  end

  assign rd_addr = {rbank_q, rcnt_q};
  assign rd_dat  = mem_q[rd_addr];

  // Output register: data and index hold between bursts, valid/last drop to 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_idx_q   <= '0;
      do_re_q     <= '0;
      do_im_q     <= '0;
    end else begin
      out_valid_q <= rd_en;
      out_last_q  <= rd_en && (rcnt_q == CNT_LAST);
      if (rd_en) begin
        out_idx_q <= rcnt_q;
        do_re_q   <= rd_dat[W-1:FLOAT_PRECISION];
        do_im_q   <= rd_dat[FLOAT_PRECISION-1:0];
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_idx   = out_idx_q;
  assign bus.do_re     = do_re_q;
  assign bus.do_im     = do_im_q;
  assign bus.busy      = (wcnt_q != '0) || (state_q == R_OUT);

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Purpose: self-checking bench for the bit-reversal reorder buffer at N=8 and N=256.
// Latency: checks bin 0 one edge after the last input sample and N-sample gap-free bursts.
// Backpressure: none in the design; the bench drives valid-only input with optional gaps.
module tb_fft_bitrev_reorder;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  fft_bitrev_reorder_if #(.FLOAT_PRECISION(64), .logn(3)) b3 ();
  fft_bitrev_reorder_if #(.FLOAT_PRECISION(64), .logn(8)) b8 ();

  fft_bitrev_reorder #(.FLOAT_PRECISION(64), .logn(3)) dut3 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b3)
  );

  fft_bitrev_reorder #(.FLOAT_PRECISION(64), .logn(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b8)
  );

  typedef struct {
    logic [63:0] re;
    logic [63:0] im;
    int          idx;
    logic        last;
  } smp_t;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: arrival-order partial frames and expected natural-order outputs.
  smp_t part3[$];
  smp_t part8[$];
  smp_t exp3[$];
  smp_t exp8[$];

  // Observations of the N=8 output stream.
  logic [63:0] log3_re[$];
  logic [63:0] log3_im[$];
  int          runs3[$];
  int          run3  = 0;
  int          last3 = 0;

  int lit[8] = '{0, 4, 2, 6, 1, 5, 3, 7};

  function automatic int brev(input int j, input int bits);
    int r = 0;
    for (int b = 0; b < bits; b++) begin
      r = r * 2 + ((j >> b) & 1);
    end
    return r;
  endfunction

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] req);
    n_tests++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", nm, got, req);
    end
  endtask

  // Bin k of a finished frame is the sample that arrived at index bitrev(k).
  task automatic model_push(input int w, input logic [63:0] re, input logic [63:0] im);
    smp_t s;
    smp_t e;
    s.re = re; s.im = im; s.idx = 0; s.last = 1'b0;
    if (w == 3) begin
      part3.push_back(s);
      if (part3.size() == 8) begin
        for (int k = 0; k < 8; k++) begin
          e = part3[brev(k, 3)]; e.idx = k; e.last = (k == 7);
          exp3.push_back(e);
        end
        part3.delete();
      end
    end else begin
      part8.push_back(s);
      if (part8.size() == 256) begin
        for (int k = 0; k < 256; k++) begin
          e = part8[brev(k, 8)]; e.idx = k; e.last = (k == 255);
          exp8.push_back(e);
        end
        part8.delete();
      end
    end
  endtask

  task automatic chk(input int w, input logic v, input logic [63:0] re, input logic [63:0] im,
                     input int idx, input logic last);
    smp_t e;
    if (v === 1'b1) begin
      if ((w == 3 && exp3.size() == 0) || (w == 8 && exp8.size() == 0)) begin
        n_tests++;
        n_fail++;
        $display("FAIL spurious_out_n%0d: got out_valid=1 required 0 (no frame pending)", w);
      end else begin
        if (w == 3) e = exp3.pop_front();
        else        e = exp8.pop_front();
        check($sformatf("do_re_n%0d_bin%0d", w, e.idx), re, e.re);
        check($sformatf("do_im_n%0d_bin%0d", w, e.idx), im, e.im);
        check($sformatf("out_idx_n%0d", w), 64'(idx), 64'(e.idx));
        check($sformatf("out_last_n%0d_bin%0d", w, e.idx), 64'(last), 64'(e.last));
      end
    end else begin
      check($sformatf("out_valid_known_n%0d", w), 64'(v), 64'(1'b0));
      check($sformatf("out_last_idle_n%0d", w), 64'(last), 64'd0);
    end
  endtask

  // Compare process: every negedge both output streams are checked against the model.
  always @(negedge clk) begin
    if (rst_n === 1'b1 || rst_n === 1'b0) begin
      chk(3, b3.out_valid, b3.do_re, b3.do_im, int'(b3.out_idx), b3.out_last);
      chk(8, b8.out_valid, b8.do_re, b8.do_im, int'(b8.out_idx), b8.out_last);
      if (b3.out_valid === 1'b1) begin
        run3++;
        log3_re.push_back(b3.do_re);
        log3_im.push_back(b3.do_im);
        if (b3.out_last === 1'b1) last3++;
      end else if (run3 > 0) begin
        runs3.push_back(run3);
        run3 = 0;
      end
    end
  end

  task automatic drive3(input logic v, input logic [63:0] re, input logic [63:0] im);
    b3.in_valid = v; b3.di_re = re; b3.di_im = im;
    if (v) model_push(3, re, im);
  endtask

  task automatic drive8(input logic v, input logic [63:0] re, input logic [63:0] im);
    b8.in_valid = v; b8.di_re = re; b8.di_im = im;
    if (v) model_push(8, re, im);
  endtask

  // One N=8 frame; re=base_re+j, im=base_im+j, optional idle cycles after j=2 and j=5.
  task automatic send3(input int base_re, input int base_im, input int gap);
    for (int j = 0; j < 8; j++) begin
      drive3(1'b1, 64'(base_re + j), 64'(base_im + j));
      @(posedge clk); #1;
      drive3(1'b0, 64'd0, 64'd0);
      if (gap > 0 && (j == 2 || j == 5)) begin
        repeat (gap) @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic drain(input int w, input int budget);
    int c = 0;
    while (((w == 3) ? exp3.size() : exp8.size()) != 0 && c < budget) begin
      @(negedge clk);
      c++;
    end
    check($sformatf("drain_pending_n%0d", w), 64'((w == 3) ? exp3.size() : exp8.size()), 64'd0);
    repeat (3) @(negedge clk);
  endtask

  // Pins the model with hand-derived bit-reversed orderings of one 8-sample frame.
  task automatic check_lit(input string nm, input int s0, input int base_re, input int base_im);
    check({nm, "_count"}, 64'(log3_re.size() >= s0 + 8), 64'd1);
    if (log3_re.size() >= s0 + 8) begin
      for (int i = 0; i < 8; i++) begin
        check($sformatf("%s_re%0d", nm, i), log3_re[s0+i], 64'(base_re + lit[i]));
        check($sformatf("%s_im%0d", nm, i), log3_im[s0+i], 64'(base_im + lit[i]));
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish required finish within 2ms");
    $fatal(1, "timeout");
  end

  initial begin
    int s0;
    int r0;
    int l0;
    b3.in_valid = 1'b0; b3.di_re = '0; b3.di_im = '0;
    b8.in_valid = 1'b0; b8.di_re = '0; b8.di_im = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;

    // Reset state of both instances.
    @(negedge clk);
    check("rst_valid3", 64'(b3.out_valid), 64'd0);
    check("rst_last3",  64'(b3.out_last),  64'd0);
    check("rst_idx3",   64'(b3.out_idx),   64'd0);
    check("rst_re3",    b3.do_re,          64'd0);
    check("rst_im3",    b3.do_im,          64'd0);
    check("rst_busy3",  64'(b3.busy),      64'd0);
    check("rst_valid8", 64'(b8.out_valid), 64'd0);
    check("rst_busy8",  64'(b8.busy),      64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: single continuous frame, latency and burst shape.
    s0 = log3_re.size(); r0 = runs3.size(); l0 = last3;
    send3(0, 100, 0);
    @(negedge clk);
    check("t1_valid_before_latency", 64'(b3.out_valid), 64'd0);
    check("t1_busy_replay", 64'(b3.busy), 64'd1);
    @(negedge clk);
    check("t1_first_valid", 64'(b3.out_valid), 64'd1);
    check("t1_first_idx", 64'(b3.out_idx), 64'd0);
    drain(3, 40);
    check_lit("t1", s0, 0, 100);
    check("t1_runs", 64'(runs3.size() - r0), 64'd1);
    if (runs3.size() > r0) check("t1_run_len", 64'(runs3[r0]), 64'd8);
    check("t1_lasts", 64'(last3 - l0), 64'd1);
    check("t1_busy_done", 64'(b3.busy), 64'd0);

    // 2: gapped input, still one 8-sample burst.
    s0 = log3_re.size(); r0 = runs3.size();
    send3(0, 100, 3);
    drain(3, 40);
    check_lit("t2", s0, 0, 100);
    check("t2_runs", 64'(runs3.size() - r0), 64'd1);
    if (runs3.size() > r0) check("t2_run_len", 64'(runs3[r0]), 64'd8);

    // 3: back-to-back frames produce a 16-sample burst with two last pulses.
    s0 = log3_re.size(); r0 = runs3.size(); l0 = last3;
    send3(0, 200, 0);
    send3(16, 216, 0);
    drain(3, 60);
    check_lit("t3a", s0, 0, 200);
    check_lit("t3b", s0 + 8, 16, 216);
    check("t3_runs", 64'(runs3.size() - r0), 64'd1);
    if (runs3.size() > r0) check("t3_run_len", 64'(runs3[r0]), 64'd16);
    check("t3_lasts", 64'(last3 - l0), 64'd2);

    // 4: three frames with 5 idle cycles between, exercising the bank toggle again.
    s0 = log3_re.size();
    for (int f = 0; f < 3; f++) begin
      send3(32 + 8 * f, 300 + 8 * f, 0);
      repeat (5) @(posedge clk);
      #1;
    end
    drain(3, 60);
    check_lit("t4a", s0, 32, 300);
    check_lit("t4b", s0 + 8, 40, 308);
    check_lit("t4c", s0 + 16, 48, 316);

    // 5: reset after j=4 drops the partial frame.
    s0 = log3_re.size();
    for (int j = 0; j < 5; j++) begin
      b3.in_valid = 1'b1; b3.di_re = 64'(90 + j); b3.di_im = 64'(190 + j);
      @(posedge clk); #1;
    end
    b3.in_valid = 1'b0;
    check("t5_busy_partial", 64'(b3.busy), 64'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("t5_rst_valid", 64'(b3.out_valid), 64'd0);
    check("t5_rst_busy",  64'(b3.busy),      64'd0);
    check("t5_rst_re",    b3.do_re,          64'd0);
    check("t5_rst_idx",   64'(b3.out_idx),   64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("t5_no_partial_out", 64'(log3_re.size() - s0), 64'd0);
    send3(50, 150, 0);
    drain(3, 40);
    check_lit("t5", s0, 50, 150);

    // 6: N=256, four random frames with random gaps.
    for (int f = 0; f < 4; f++) begin
      for (int j = 0; j < 256; j++) begin
        drive8(1'b1, {$urandom, $urandom}, {$urandom, $urandom});
        @(posedge clk); #1;
        b8.in_valid = 1'b0;
        if ($urandom_range(0, 3) == 0) begin
          repeat ($urandom_range(1, 3)) @(posedge clk);
          #1;
        end
      end
    end
    drain(8, 2000);
    check("t6_busy_done", 64'(b8.busy), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
